// File: rtl/hub75_rx_capture.sv
// HUB75 panel-side receiver: synchronises the panel pins, rebuilds bit-planes per row, streams pixels out.
// Build option HUB75_RX_GLITCH_FILTER_EN adds a 3-sample majority filter on HCLK/STB (+2 clk latency).
module hub75_rx_capture #(
  parameter int hpixel_p = 64,
  parameter int vpixel_p = 64,
  parameter int bpp_p    = 8,
  localparam int addr_width_p = $clog2(hpixel_p*vpixel_p)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_enable,
  input  logic                    i_clr_err,
  input  logic                    HCLK,
  input  logic                    STB,
  input  logic                    OE,
  input  logic                    A,
  input  logic                    B,
  input  logic                    C,
  input  logic                    D,
  input  logic                    E,
  input  logic                    R1,
  input  logic                    G1,
  input  logic                    B1,
  input  logic                    R2,
  input  logic                    G2,
  input  logic                    B2,
  output logic [addr_width_p-1:0] o_wr_addr,
  output logic [3*bpp_p-1:0]      o_wr_data,
  output logic                    o_wr_en,
  output logic                    o_frame_done,
  output logic                    o_err_cols,
  output logic                    o_overrun
);
  localparam int ROWS = vpixel_p/2;
  localparam int XW   = $clog2(hpixel_p);
  localparam int CW   = $clog2(hpixel_p+1);
  localparam int PW   = (bpp_p > 1) ? $clog2(bpp_p) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_ROW, CAPTURE} state_t;

  state_t state, state_nxt;
  logic [13:0] pin_s1, pin_s2;
  logic hclk_f, stb_f, hclk_q, stb_q, hclk_rise, stb_rise;
  logic [10:0] dat;
  logic [4:0] row_in, last_row, cap_row, wb_row;
  logic [5:0] pix_in;
  logic row_chg, merge, row_err, final_merge, col_err;
  logic [PW-1:0] plane_q, eff_plane;
  logic [CW-1:0] col_cnt, col_nxt;
  logic [hpixel_p-1:0][5:0] sbuf, sbuf_nxt;
  logic [1:0][hpixel_p-1:0][2:0][bpp_p-1:0] acc, wbuf;
  logic wb_start, wb_busy, wb_seg, wb_last;
  logic [XW-1:0] wb_col;
  logic [addr_width_p-1:0] wr_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pin_s1 <= '0;
      pin_s2 <= '0;
    end else begin
      pin_s1 <= {HCLK, STB, OE, E, D, C, B, A, R1, G1, B1, R2, G2, B2};
      pin_s2 <= pin_s1;
    end
  end

`ifdef HUB75_RX_GLITCH_FILTER_EN
  logic [2:0] hclk_h, stb_h;
  logic [10:0] dat_d1, dat_d2;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hclk_h <= '0;
      stb_h  <= '0;
      dat_d1 <= '0;
      dat_d2 <= '0;
    end else begin
      hclk_h <= {hclk_h[1:0], pin_s2[13]};
      stb_h  <= {stb_h[1:0], pin_s2[12]};
      dat_d1 <= pin_s2[10:0];
      dat_d2 <= dat_d1;
    end
  end
  assign hclk_f = (hclk_h[0] & hclk_h[1]) | (hclk_h[0] & hclk_h[2]) | (hclk_h[1] & hclk_h[2]);
  assign stb_f  = (stb_h[0] & stb_h[1]) | (stb_h[0] & stb_h[2]) | (stb_h[1] & stb_h[2]);
  assign dat    = dat_d2;
`else
  assign hclk_f = pin_s2[13];
  assign stb_f  = pin_s2[12];
  assign dat    = pin_s2[10:0];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hclk_q <= 1'b0;
      stb_q  <= 1'b0;
    end else begin
      hclk_q <= hclk_f;
      stb_q  <= stb_f;
    end
  end

  assign hclk_rise = hclk_f & ~hclk_q;
  assign stb_rise  = stb_f & ~stb_q;
  assign row_in    = dat[10:6];
  assign pix_in    = dat[5:0];
  assign row_chg   = (row_in != last_row);

  // A shift coinciding with a latch lands in the buffer before the merge reads it.
  always_comb begin
    sbuf_nxt = sbuf;
    col_nxt  = col_cnt;
    col_err  = 1'b0;
    if (hclk_rise) begin
      if (col_cnt < CW'(hpixel_p)) begin
        sbuf_nxt[col_cnt[XW-1:0]] = pix_in;
        col_nxt = col_cnt + 1'b1;
      end else begin
        col_err = 1'b1;
      end
    end
    if (stb_rise) begin
      if (col_nxt != CW'(hpixel_p)) col_err = 1'b1;
      col_nxt = '0;
    end
  end

  always_comb begin
    state_nxt = state;
    merge     = 1'b0;
    row_err   = 1'b0;
    case (state)
      IDLE:     if (i_enable) state_nxt = WAIT_ROW;
      WAIT_ROW: if (stb_rise && row_chg) begin
        merge     = 1'b1;
        state_nxt = CAPTURE;
      end
      CAPTURE:  if (stb_rise) begin
        merge   = 1'b1;
        row_err = row_chg && (plane_q != '0);
      end
      default:  state_nxt = IDLE;
    endcase
    if (!i_enable) begin
      state_nxt = IDLE;
      merge     = 1'b0;
      row_err   = 1'b0;
    end
  end

  // plane_q holds the next plane to merge; a row change restarts at plane 0.
  assign eff_plane   = row_chg ? '0 : plane_q;
  assign final_merge = merge && (eff_plane == PW'(bpp_p-1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sbuf    <= '0;
      col_cnt <= '0;
      acc     <= '0;
    end else begin
      sbuf    <= sbuf_nxt;
      col_cnt <= col_nxt;
      if (merge)
        for (int s = 0; s < 2; s++)
          for (int c = 0; c < hpixel_p; c++)
            for (int ch = 0; ch < 3; ch++)
              acc[s][c][ch] <= ((eff_plane == '0) ? '0 : acc[s][c][ch]) |
                               (bpp_p'(sbuf_nxt[c][3*(1-s)+ch]) << eff_plane);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      plane_q    <= '0;
      last_row   <= '0;
      cap_row    <= '0;
      wb_start   <= 1'b0;
      o_err_cols <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (stb_rise) last_row <= row_in;
      if (state == IDLE) plane_q <= '0;
      else if (merge)    plane_q <= final_merge ? '0 : eff_plane + 1'b1;
      if (final_merge) cap_row <= row_in;
      wb_start   <= final_merge;
      o_err_cols <= (o_err_cols & ~i_clr_err) | ((state != IDLE) & (col_err | row_err));
      o_overrun  <= (o_overrun & ~i_clr_err) | (final_merge & (wb_busy | wb_start));
    end
  end

  assign wb_last = wb_seg && (wb_col == XW'(hpixel_p-1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wbuf         <= '0;
      wb_busy      <= 1'b0;
      wb_seg       <= 1'b0;
      wb_col       <= '0;
      wb_row       <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= i_enable && wb_busy && wb_last && (wb_row == 5'(ROWS-1));
      if (!i_enable) begin
        wb_busy <= 1'b0;
      end else if (wb_start) begin
        wbuf    <= acc;
        wb_busy <= 1'b1;
        wb_seg  <= 1'b0;
        wb_col  <= '0;
        wb_row  <= cap_row;
      end else if (wb_busy) begin
        wb_col <= wb_col + 1'b1;
        if (wb_col == XW'(hpixel_p-1)) begin
          wb_seg <= ~wb_seg;
          if (wb_seg) wb_busy <= 1'b0;
        end
      end
    end
  end

  assign wr_addr = (addr_width_p'(wb_seg) * addr_width_p'(ROWS) + addr_width_p'(wb_row)) *
                   addr_width_p'(hpixel_p) + addr_width_p'(wb_col);

  assign o_wr_en   = wb_busy;
  assign o_wr_addr = wb_busy ? wr_addr : '0;
  assign o_wr_data = wb_busy ? wbuf[wb_seg][wb_col] : '0;
endmodule

// File: tb/tb_hub75_rx_capture.sv
// Randomised HUB75 stream into hub75_rx_capture, checked against a pixel-level framebuffer model.
module tb_hub75_rx_capture;
  localparam int H = 64, ROWS = 32, BPP = 8;

  logic clk = 0, rst_n = 0, i_enable = 0, i_clr_err = 0;
  logic HCLK = 0, STB = 0, OE = 0, A = 0, B = 0, C = 0, D = 0, E = 0;
  logic R1 = 0, G1 = 0, B1 = 0, R2 = 0, G2 = 0, B2 = 0;
  logic [11:0] o_wr_addr;
  logic [23:0] o_wr_data;
  logic o_wr_en, o_frame_done, o_err_cols, o_overrun;

  int n_cmp = 0, n_bad = 0;
  int pix [2][H];
  int fb_exp [4096];
  int fb_obs [4096];
  int log_q [$];
  int fd_cnt = 0, fd_wide = 0, fd_after_last = 0, prev_addr = 0;
  logic prev_en = 0, prev_fd = 0;

  always #5 clk = ~clk;

  hub75_rx_capture dut (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_clr_err(i_clr_err),
    .HCLK(HCLK), .STB(STB), .OE(OE), .A(A), .B(B), .C(C), .D(D), .E(E),
    .R1(R1), .G1(G1), .B1(B1), .R2(R2), .G2(G2), .B2(B2),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_wr_en(o_wr_en),
    .o_frame_done(o_frame_done), .o_err_cols(o_err_cols), .o_overrun(o_overrun)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (o_wr_en) begin
      fb_obs[o_wr_addr] = int'(o_wr_data);
      log_q.push_back(int'(o_wr_addr));
    end
    if (o_frame_done) begin
      fd_cnt++;
      if (prev_fd) fd_wide++;
      if (prev_en && prev_addr == 4095) fd_after_last++;
    end
    prev_en   = o_wr_en;
    prev_fd   = o_frame_done;
    prev_addr = int'(o_wr_addr);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_px(input int c, input int k);
    R1 = pix[0][c][16+k]; G1 = pix[0][c][8+k]; B1 = pix[0][c][k];
    R2 = pix[1][c][16+k]; G2 = pix[1][c][8+k]; B2 = pix[1][c][k];
  endtask

  task automatic stb(input int row);
    {E, D, C, B, A} = 5'(row);
    OE = 1'($urandom);
    STB = 1; tick(2);
    STB = 0; tick(2);
  endtask

  task automatic send_plane(input int row, input int k, input int ncols);
    for (int c = 0; c < ncols; c++) begin
      set_px(c, k);
      HCLK = 1; tick(2);
      HCLK = 0; tick(2);
    end
    stb(row);
  endtask

  task automatic model_row(input int row);
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < H; c++) fb_exp[(s*ROWS + row)*H + c] = pix[s][c];
  endtask

  task automatic send_row(input int row);
    for (int k = 0; k < BPP; k++) send_plane(row, k, H);
    model_row(row);
  endtask

  task automatic rand_pix(input int mask);
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < H; c++) pix[s][c] = int'($urandom) & mask;
  endtask

  function automatic int row_mism(input int row);
    int m = 0;
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < H; c++)
        if (fb_obs[(s*ROWS + row)*H + c] != fb_exp[(s*ROWS + row)*H + c]) m++;
    return m;
  endfunction

  task automatic wait_wr(input string tag);
    int n = 0;
    while (!o_wr_en && n < 400) begin @(negedge clk); n++; end
    chk({tag, "_wr_seen"}, o_wr_en, 1);
  endtask

  task automatic clr_err();
    i_clr_err = 1; tick(1);
    i_clr_err = 0;
  endtask

  initial begin
    int lsz, idx, bad, fd0;
    for (int a = 0; a < 4096; a++) begin fb_obs[a] = -1; fb_exp[a] = -1; end

    // reset state
    tick(3);
    @(negedge clk);
    chk("rst_wr_en", o_wr_en, 0);
    chk("rst_wr_addr", o_wr_addr, 0);
    chk("rst_wr_data", o_wr_data, 0);
    chk("rst_frame_done", o_frame_done, 0);
    chk("rst_err_cols", o_err_cols, 0);
    chk("rst_overrun", o_overrun, 0);
    tick(1);
    rst_n = 1; tick(2);
    i_enable = 1; tick(2);

    // row 3: R1 solid, B2 set on col 5 in planes 0 and 2
    for (int c = 0; c < H; c++) begin pix[0][c] = 32'hFF0000; pix[1][c] = (c == 5) ? 5 : 0; end
    lsz = log_q.size();
    send_row(3);
    tick(150);
    @(negedge clk);
    chk("t1_writes", log_q.size() - lsz, 128);
    chk("t1_addr192", fb_obs[192], 32'hFF0000);
    chk("t1_addr255", fb_obs[255], 32'hFF0000);
    chk("t1_addr2240", fb_obs[2240], 0);
    chk("t1_addr2245", fb_obs[(32+3)*64+5], 5);
    chk("t1_row_mism", row_mism(3), 0);
    chk("t1_err_cols", o_err_cols, 0);

    // row 7: short plane sets err_cols; clear; remaining planes clean
    rand_pix(32'hFFFFFF);
    tick(1);
    send_plane(7, 0, 63);
    tick(2);
    @(negedge clk);
    chk("short_err_set", o_err_cols, 1);
    tick(1);
    clr_err();
    @(negedge clk);
    chk("short_err_clr", o_err_cols, 0);
    tick(1);
    for (int k = 1; k < BPP; k++) send_plane(7, k, H);
    tick(150);
    @(negedge clk);
    chk("row7_err_stays0", o_err_cols, 0);

    // row 9: plane 0 column 63 delivered as a 1-clk HCLK glitch
    rand_pix(32'hFFFFFF);
    tick(1);
    for (int c = 0; c < H-1; c++) begin
      set_px(c, 0); HCLK = 1; tick(2); HCLK = 0; tick(2);
    end
    set_px(H-1, 0); HCLK = 1; tick(1); HCLK = 0; tick(3);
    stb(9);
    for (int k = 1; k < BPP; k++) send_plane(9, k, H);
    model_row(9);
    tick(150);
    @(negedge clk);
`ifdef HUB75_RX_GLITCH_FILTER_EN
    chk("glitch_err_cols", o_err_cols, 1);
`else
    chk("glitch_err_cols", o_err_cols, 0);
    chk("glitch_row_mism", row_mism(9), 0);
`endif
    tick(1);
    clr_err();

    // overrun: row 10 then a fast zero-column row 11 lands mid-writeout
    rand_pix(32'h7F7F7F);
    lsz = log_q.size();
    send_row(10);
    for (int k = 0; k < BPP; k++) stb(11);
    for (int s = 0; s < 2; s++) for (int c = 0; c < H; c++) pix[s][c] = 0;
    model_row(11);
    tick(200);
    @(negedge clk);
    chk("ovr_flag", o_overrun, 1);
    chk("ovr_err_cols", o_err_cols, 1);
    idx = -1;
    for (int i = lsz; i < log_q.size(); i++)
      if (idx < 0 && ((log_q[i] / H) % ROWS) == 11) idx = i;
    chk("ovr_row11_seen", idx >= 0, 1);
    if (idx >= 0) begin
      chk("ovr_row10_truncated", (idx - lsz) > 0 && (idx - lsz) < 128, 1);
      chk("ovr_row11_count", log_q.size() - idx, 128);
      bad = 0;
      for (int k = 0; k < 128 && idx + k < log_q.size(); k++)
        if (log_q[idx+k] != ((k / H)*ROWS + 11)*H + (k % H)) bad++;
      chk("ovr_restart_order", bad, 0);
    end
    chk("ovr_row11_mism", row_mism(11), 0);
    tick(1);
    clr_err();
    @(negedge clk);
    chk("ovr_clr_overrun", o_overrun, 0);
    chk("ovr_clr_err_cols", o_err_cols, 0);
    tick(1);

    // disable mid-writeout
    for (int k = 0; k < BPP; k++) stb(12);
    wait_wr("dis");
    tick(10);
    i_enable = 0;
    @(posedge clk);
    @(negedge clk);
    chk("dis_wr_en", o_wr_en, 0);
    lsz = log_q.size();
    tick(20);
    chk("dis_no_writes", log_q.size() - lsz, 0);
    clr_err();
    i_enable = 1; tick(2);

    // full frame, random pixels
    lsz = log_q.size();
    fd0 = fd_cnt;
    for (int r = 0; r < ROWS; r++) begin
      rand_pix(32'hFFFFFF);
      send_row(r);
    end
    tick(200);
    @(negedge clk);
    chk("frame_writes", log_q.size() - lsz, 4096);
    bad = 0;
    for (int r = 0; r < ROWS; r++) bad += row_mism(r);
    chk("frame_mism", bad, 0);
    chk("frame_done_pulses", fd_cnt - fd0, 1);
    chk("frame_done_width", fd_wide, 0);
    chk("frame_done_after_last", fd_after_last, 1);
    chk("frame_err_cols", o_err_cols, 0);
    chk("frame_overrun", o_overrun, 0);
    tick(1);

    // synchronous reset mid-writeout
    for (int k = 0; k < BPP; k++) stb(5);
    wait_wr("rst2");
    tick(5);
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst2_wr_en", o_wr_en, 0);
    chk("rst2_wr_addr", o_wr_addr, 0);
    chk("rst2_wr_data", o_wr_data, 0);
    chk("rst2_err_cols", o_err_cols, 0);
    chk("rst2_overrun", o_overrun, 0);
    chk("rst2_frame_done", o_frame_done, 0);
    tick(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
